// File: rtl/ym3438_slot_sequencer.sv
// ---------------------------------------------------------------------------
// ym3438_slot_sequencer
//
// Per-slot sequencer for the operator/envelope datapaths. It runs from MCLK
// and is stepped by the rising edge of the prescaler's c1 phase clock. One
// step advances the 24-slot operator cycle. A wrap of the cycle is one sample,
// and that sample is the timer A tick. Every TMRB_DIV samples give one
// timer B tick.
//
// Ports
//   MCLK        in   master clock; all state changes on its rising edge
//   RESET       in   asynchronous active-high reset
//   c1          in   prescaler phase clock 1; its rising edge is the slot step
//   c2          in   prescaler phase clock 2; only checked for overlap with c1
//   reset_fsm   in   slot restart request; acted on only at a step
//   step        out  one-MCLK pulse, registered copy of the c1 edge detect
//   slot        out  current slot, 0..NUM_SLOTS-1
//   channel     out  slot mod 6 (separate counter)
//   op_sel      out  slot / 6 (separate counter)
//   slot0       out  high while slot == 0
//   sample_tick out  one-MCLK pulse on the last-slot -> 0 wrap
//   tmrb_tick   out  one-MCLK pulse on every TMRB_DIV-th sample_tick
//   phase_err   out  sticky; c1 and c2 were sampled high together
// ---------------------------------------------------------------------------
module ym3438_slot_sequencer #(
  parameter int NUM_SLOTS = 24,
  parameter int TMRB_DIV  = 16
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       c1,
  input  logic       c2,
  input  logic       reset_fsm,
  output logic       step,
  output logic [4:0] slot,
  output logic [2:0] channel,
  output logic [1:0] op_sel,
  output logic       slot0,
  output logic       sample_tick,
  output logic       tmrb_tick,
  output logic       phase_err
);

  localparam int TW = (TMRB_DIV > 1) ? $clog2(TMRB_DIV) : 1;

  localparam logic [4:0]    SLOT_LAST = 5'(NUM_SLOTS - 1);
  localparam logic [2:0]    CHAN_LAST = 3'd5;
  localparam logic [TW-1:0] TMRB_LAST = TW'(TMRB_DIV - 1);

  logic          c1_q,          c1_d;
  logic          step_q,        step_d;
  logic [4:0]    slot_q,        slot_d;
  logic [2:0]    channel_q,     channel_d;
  logic [1:0]    op_sel_q,      op_sel_d;
  logic          slot0_q,       slot0_d;
  logic          sample_tick_q, sample_tick_d;
  logic [TW-1:0] tmrb_cnt_q,    tmrb_cnt_d;
  logic          tmrb_tick_q,   tmrb_tick_d;
  logic          phase_err_q,   phase_err_d;

  logic step_int;
  logic slot_wrap;
  logic chan_wrap;
  logic tmrb_wrap;

  assign step_int  = c1 & ~c1_q;
  assign slot_wrap = (slot_q == SLOT_LAST);
  assign chan_wrap = (channel_q == CHAN_LAST);
  assign tmrb_wrap = (tmrb_cnt_q == TMRB_LAST);

  always_comb begin
    c1_d          = c1;
    step_d        = step_int;
    slot_d        = slot_q;
    channel_d     = channel_q;
    op_sel_d      = op_sel_q;
    slot0_d       = slot0_q;
    tmrb_cnt_d    = tmrb_cnt_q;
    sample_tick_d = 1'b0;
    tmrb_tick_d   = 1'b0;
    phase_err_d   = phase_err_q | (c1 & c2);

    if (step_int) begin
      if (reset_fsm) begin
        // Restart wins over a pending wrap, so no ticks from this step.
        slot_d     = '0;
        channel_d  = '0;
        op_sel_d   = '0;
        slot0_d    = 1'b1;
        tmrb_cnt_d = '0;
      end else begin
        slot_d  = slot_wrap ? 5'd0 : slot_q + 5'd1;
        slot0_d = slot_wrap;
        // Channel and operator are kept as their own counters rather than
        // divided from slot; the slot wrap re-aligns them in any case.
        channel_d = (slot_wrap || chan_wrap) ? 3'd0 : channel_q + 3'd1;
        if (slot_wrap) begin
          op_sel_d = '0;
        end else if (chan_wrap) begin
          op_sel_d = op_sel_q + 2'd1;
        end
        if (slot_wrap) begin
          sample_tick_d = 1'b1;
          tmrb_cnt_d    = tmrb_wrap ? '0 : tmrb_cnt_q + TW'(1);
          tmrb_tick_d   = tmrb_wrap;
        end
      end
    end
  end

  // c1_q resets high so a c1 already high at reset release is not a step.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      c1_q          <= 1'b1;
      step_q        <= 1'b0;
      slot_q        <= '0;
      channel_q     <= '0;
      op_sel_q      <= '0;
      slot0_q       <= 1'b1;
      sample_tick_q <= 1'b0;
      tmrb_cnt_q    <= '0;
      tmrb_tick_q   <= 1'b0;
      phase_err_q   <= 1'b0;
    end else begin
      c1_q          <= c1_d;
      step_q        <= step_d;
      slot_q        <= slot_d;
      channel_q     <= channel_d;
      op_sel_q      <= op_sel_d;
      slot0_q       <= slot0_d;
      sample_tick_q <= sample_tick_d;
      tmrb_cnt_q    <= tmrb_cnt_d;
      tmrb_tick_q   <= tmrb_tick_d;
      phase_err_q   <= phase_err_d;
    end
  end

  assign step        = step_q;
  assign slot        = slot_q;
  assign channel     = channel_q;
  assign op_sel      = op_sel_q;
  assign slot0       = slot0_q;
  assign sample_tick = sample_tick_q;
  assign tmrb_tick   = tmrb_tick_q;
  assign phase_err   = phase_err_q;

endmodule

// File: tb/tb_ym3438_slot_sequencer.sv
module tb_ym3438_slot_sequencer;

  localparam int NS = 24;
  localparam int TD = 16;

  logic       MCLK = 1'b0;
  logic       RESET;
  logic       c1;
  logic       c2;
  logic       reset_fsm;
  logic       step;
  logic [4:0] slot;
  logic [2:0] channel;
  logic [1:0] op_sel;
  logic       slot0;
  logic       sample_tick;
  logic       tmrb_tick;
  logic       phase_err;

  ym3438_slot_sequencer #(.NUM_SLOTS(NS), .TMRB_DIV(TD)) dut (
    .MCLK(MCLK), .RESET(RESET), .c1(c1), .c2(c2), .reset_fsm(reset_fsm),
    .step(step), .slot(slot), .channel(channel), .op_sel(op_sel),
    .slot0(slot0), .sample_tick(sample_tick), .tmrb_tick(tmrb_tick),
    .phase_err(phase_err)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [4:0] slot;
    logic [2:0] ch;
    logic [1:0] op;
    logic       s0;
    logic       st;
    logic       tt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;

  // Monitor: pulse counts, sampled on the falling edge.
  int cnt_step = 0;
  int cnt_st   = 0;
  int cnt_tt   = 0;
  always @(negedge MCLK) begin
    if (RESET !== 1'b1) begin
      if (step === 1'b1)        cnt_step <= cnt_step + 1;
      if (sample_tick === 1'b1) cnt_st   <= cnt_st + 1;
      if (tmrb_tick === 1'b1)   cnt_tt   <= cnt_tt + 1;
    end
  end

  // Reference model
  int m_slot  = 0;
  int m_tcnt  = 0;
  int e_steps = 0;
  int e_st    = 0;
  int e_tt    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_step(input bit rfsm, output exp_t e);
    e.st = 1'b0;
    e.tt = 1'b0;
    if (rfsm) begin
      m_slot = 0;
      m_tcnt = 0;
    end else if (m_slot == NS - 1) begin
      m_slot = 0;
      m_tcnt = (m_tcnt + 1) % TD;
      e.st = 1'b1;
      e.tt = (m_tcnt == 0);
      e_st++;
      if (m_tcnt == 0) e_tt++;
    end else begin
      m_slot++;
    end
    e.slot = 5'(m_slot);
    e.ch   = 3'(m_slot % 6);
    e.op   = 2'(m_slot / 6);
    e.s0   = (m_slot == 0);
    e_steps++;
  endtask

  task automatic pulse(input bit rfsm, input bit with_c2, input int hi, input int lo);
    exp_t e;
    exp_t g;
    bit seen;
    seen = 1'b0;
    model_step(rfsm, e);
    sb.push_back(e);
    @(negedge MCLK);
    c1 = 1'b1;
    c2 = with_c2;
    reset_fsm = rfsm;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge MCLK);
      c2 = 1'b0;
      reset_fsm = 1'b0;
      if (step === 1'b1) seen = 1'b1;
    end
    g = sb.pop_front();
    if (!seen) begin
      chk("step_timeout", 32'd0, 32'd1);
    end else begin
      chk("slot", 32'(slot), 32'(g.slot));
      chk("channel", 32'(channel), 32'(g.ch));
      chk("op_sel", 32'(op_sel), 32'(g.op));
      chk("slot0", 32'(slot0), 32'(g.s0));
      chk("sample_tick", 32'(sample_tick), 32'(g.st));
      chk("tmrb_tick", 32'(tmrb_tick), 32'(g.tt));
    end
    repeat (hi - 1) @(negedge MCLK);
    c1 = 1'b0;
    repeat (lo) @(negedge MCLK);
  endtask

  task automatic check_counts(input string tag);
    @(posedge MCLK);
    #1;
    chk({tag, "_steps"}, 32'(cnt_step), 32'(e_steps));
    chk({tag, "_sample_ticks"}, 32'(cnt_st), 32'(e_st));
    chk({tag, "_tmrb_ticks"}, 32'(cnt_tt), 32'(e_tt));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_slot"}, 32'(slot), 32'd0);
    chk({tag, "_channel"}, 32'(channel), 32'd0);
    chk({tag, "_op_sel"}, 32'(op_sel), 32'd0);
    chk({tag, "_slot0"}, 32'(slot0), 32'd1);
    chk({tag, "_step"}, 32'(step), 32'd0);
    chk({tag, "_sample_tick"}, 32'(sample_tick), 32'd0);
    chk({tag, "_tmrb_tick"}, 32'(tmrb_tick), 32'd0);
    chk({tag, "_phase_err"}, 32'(phase_err), 32'd0);
  endtask

  initial begin
    int steps_before;
    int slot_before;

    // Reset with c1 held high: no step until c1 falls and rises again.
    RESET = 1'b1; c1 = 1'b1; c2 = 1'b0; reset_fsm = 1'b0;
    repeat (3) @(negedge MCLK);
    check_reset_vals("rst");
    RESET = 1'b0;
    repeat (6) @(negedge MCLK);
    check_reset_vals("rst_c1_high");
    c1 = 1'b0;
    repeat (2) @(negedge MCLK);
    check_counts("after_rst");

    // One full slot cycle (slot 13 -> channel 1, op_sel 2 checked via model).
    for (int i = 0; i < NS; i++) begin
      pulse(1'b0, 1'b0, 2, 2);
      if (m_slot == 13) begin
        chk("slot13_channel", 32'(channel), 32'd1);
        chk("slot13_op_sel", 32'(op_sel), 32'd2);
      end
    end
    check_counts("cycle1");

    // Remaining 15 cycles to complete 16 samples -> one timer B tick.
    for (int i = 0; i < (TD - 1) * NS; i++) pulse(1'b0, 1'b0, 1, 1);
    check_counts("tmrb16");
    chk("tmrb16_sample_ticks_abs", 32'(cnt_st), 32'd16);
    chk("tmrb16_tmrb_ticks_abs", 32'(cnt_tt), 32'd1);

    // Put tmrb_cnt at 3, then reach slot 23 and restart there.
    for (int i = 0; i < 3 * NS + NS - 1; i++) pulse(1'b0, 1'b0, 1, 1);
    chk("pre_restart_slot", 32'(slot), 32'd23);
    pulse(1'b1, 1'b0, 2, 2);
    check_counts("restart23");
    // tmrb_cnt must have cleared: next tmrb tick comes after a full 16 samples.
    for (int i = 0; i < TD * NS; i++) pulse(1'b0, 1'b0, 1, 1);
    check_counts("tmrb_after_restart");

    // Restart mid-cycle at slot 7, then a normal step.
    for (int i = 0; i < 7; i++) pulse(1'b0, 1'b0, 1, 1);
    chk("pre_restart7_slot", 32'(slot), 32'd7);
    pulse(1'b1, 1'b0, 2, 2);
    pulse(1'b0, 1'b0, 2, 2);

    // reset_fsm without a step does nothing.
    slot_before = int'(slot);
    @(negedge MCLK); reset_fsm = 1'b1;
    repeat (3) @(negedge MCLK); reset_fsm = 1'b0;
    chk("rfsm_no_step_slot", 32'(slot), 32'(slot_before));

    // c1 held high 20 cycles then low 20: exactly one step.
    steps_before = cnt_step;
    pulse(1'b0, 1'b0, 20, 20);
    @(posedge MCLK); #1;
    chk("long_c1_step_delta", 32'(cnt_step - steps_before), 32'd1);
    check_counts("long_c1");

    // Phase overlap: sticky through steps, cleared by RESET only.
    chk("phase_err_before", 32'(phase_err), 32'd0);
    pulse(1'b0, 1'b1, 2, 2);
    chk("phase_err_set", 32'(phase_err), 32'd1);
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0, 1, 1);
    chk("phase_err_sticky", 32'(phase_err), 32'd1);

    // Asynchronous reset mid-cycle.
    chk("pre_async_rst_slot_nonzero", 32'(slot != 5'd0), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge MCLK);
    RESET = 1'b0;
    m_slot = 0;
    m_tcnt = 0;
    pulse(1'b0, 1'b0, 2, 2);
    chk("first_step_after_rst", 32'(slot), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ym3438_slot_sequencer.md
Name: ym3438_slot_sequencer

Overview:
- Per-slot sequencer driven by the prescaler's internal phase clocks c1/c2 and its reset_fsm pulse.
- Steps a 24-slot operator cycle once per c1 phase and decodes channel and operator indices for the operator and envelope datapaths.
- Generates the per-sample tick for timer A and a divided tick for timer B.
- Sits directly downstream of the prescaler, in the MCLK domain.

Parameters:
- NUM_SLOTS, 24, slots per sample cycle. Counter wraps at NUM_SLOTS-1.
- TMRB_DIV, 16, samples per timer B tick. Power of two, 2..256.

Ports:
- MCLK  input  1  master clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- c1  input  1  internal phase clock 1 from prescaler; its rising edge (sampled on MCLK) is the slot step.
- c2  input  1  internal phase clock 2; used only for the phase-overlap check.
- reset_fsm  input  1  synchronous slot restart request, sampled at a step.
- step  output  1  one-MCLK pulse, asserted in the cycle after a c1 rising edge is detected.
- slot  output  5  current slot, 0..NUM_SLOTS-1.
- channel  output  3  slot mod 6, range 0..5.
- op_sel  output  2  slot / 6, range 0..3.
- slot0  output  1  high while slot==0.
- sample_tick  output  1  one-MCLK pulse on the 23->0 wrap.
- tmrb_tick  output  1  one-MCLK pulse on every TMRB_DIV-th sample_tick.
- phase_err  output  1  sticky flag, set when c1 and c2 are sampled high together.

Behaviour:
- Edge detect:
  - c1_q <= c1 every MCLK.
  - step_int = c1 & ~c1_q.
  - step is the registered step_int (1 MCLK latency).
- All counters advance only on MCLK edges where step_int=1.
- Slot counter:
  - At a step, slot <= (slot==NUM_SLOTS-1) ? 0 : slot+1.
  - channel and op_sel are kept as separate registered counters, updated in the same edge as slot, never combinationally divided:
    - channel: 0..5, wraps to 0.
    - op_sel: increments when channel wraps, and clears when slot wraps.
  - slot0 is registered together with slot.
- sample_tick:
  - Asserted for exactly the one MCLK edge where slot transitions 23->0.
  - Low otherwise.
- Timer B divider:
  - tmrb_cnt (log2 TMRB_DIV bits) increments on each sample_tick.
  - tmrb_tick pulses in the same edge as the sample_tick that wraps tmrb_cnt to 0.
- reset_fsm:
  - If reset_fsm=1 at a step: slot, channel, op_sel and tmrb_cnt all go to 0, slot0 goes to 1, sample_tick and tmrb_tick stay 0.
  - This applies even if slot was 23, so the restart suppresses that wrap tick.
  - reset_fsm without a step has no effect.
- Phase check: phase_err is set when c1&c2 is sampled high on any edge. It clears only on RESET.
- RESET (asynchronous):
  - Reset values: c1_q=1, so no spurious step out of reset while c1 is high.
  - All counters are 0, slot0=1.
  - step, sample_tick, tmrb_tick and phase_err are 0.
  - Asserting RESET mid-slot aborts immediately.
  - After RESET deasserts, the first step moves slot 0->1.
- c1 held high for many MCLK produces exactly one step.
- c1 low for many MCLK produces no step; counters hold.

Test Plan:
- RESET pulse with c1=1 held -> all outputs at reset values, slot0=1, no step until c1 falls and rises again.
- 24 clean c1 pulses after reset -> slot 1..23 then 0:
  - sample_tick high exactly once, coincident with the slot 23->0 edge.
  - At slot=13, channel=1 and op_sel=2.
- 16×24 c1 pulses (TMRB_DIV=16) -> 16 sample_ticks and 1 tmrb_tick, coincident with the 16th sample_tick.
- reset_fsm=1 at a step while slot=23 -> slot=0, slot0=1, no sample_tick, tmrb_cnt=0.
  - Repeat with slot=7 -> slot=0. Next normal step -> slot=1.
- c1 held high 20 MCLK, then low 20 MCLK -> exactly one step pulse, counters advance by 1.
- Drive c1=c2=1 for one MCLK -> phase_err=1, stays 1 through further steps, cleared only by RESET.
